adc_frame_writer: RTL and testbench

ADC_FRAME_WRITER -- requirements
Module: adc_frame_writer

---
 rtl/adc_frame_writer_pkg.sv | 23 ++
 rtl/adc_frame_writer_minmax.sv | 47 ++++
 rtl/adc_frame_writer.sv | 144 ++++++++++++++
 tb/tb_adc_frame_writer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_frame_writer_pkg.sv
// Shared definitions for the ADC frame capture path and the downstream scan stage.
package adc_frame_writer_pkg;

    localparam int N_PIXELS_DEF = 576;   // 24x24 sensor
    localparam int ADDR_W_DEF   = 10;
    localparam int DATA_W_DEF   = 12;
    localparam int SETTLE_DEF   = 2;
    localparam int SETTLE_W     = 4;     // discard count fits 0..15

    // One-hot capture states; a stray multi-bit pattern recovers to IDLE.
    typedef enum logic [3:0] {
        ST_IDLE    = 4'b0001,
        ST_SETTLE  = 4'b0010,
        ST_CAPTURE = 4'b0100,
        ST_DONE    = 4'b1000
    } state_t;

    // Any state other than IDLE means a frame is in flight.
    function automatic logic state_busy(input state_t s);
        return (s != ST_IDLE);
    endfunction

endpackage

// File: rtl/adc_frame_writer_minmax.sv
// Extrema tracker: working min/max seeded by the first pixel, copied out when the frame ends.
module frame_minmax
    import adc_frame_writer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_en,
    input  logic              first,
    input  logic [DATA_W-1:0] sample,
    input  logic              latch,
    output logic [DATA_W-1:0] min_val,
    output logic [DATA_W-1:0] max_val
);

    // Lane 0 tracks the minimum, lane 1 the maximum; ties never replace the held value.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ext
            logic [DATA_W-1:0] work_reg;
            logic [DATA_W-1:0] held_reg;
            logic              better;

            assign better = (gi == 0) ? (sample < work_reg) : (sample > work_reg);

            // Update the working extreme on each pixel, publish it on the latch strobe.
            always_ff @(posedge clk) begin
                if (rst) begin
                    work_reg <= '0;
                    held_reg <= '0;
                end else begin
                    if (sample_en && (first || better)) begin
                        work_reg <= sample;
                    end
                    if (latch) begin
                        held_reg <= work_reg;
                    end
                end
            end
        end
    endgenerate

    assign min_val = g_ext[0].held_reg;
    assign max_val = g_ext[1].held_reg;

endmodule

// File: rtl/adc_frame_writer.sv
// Captures one armed frame of ADC samples into BRAM port A, with settle discard and extrema.
module adc_frame_writer
    import adc_frame_writer_pkg::*;
#(
    parameter int N_PIXELS       = N_PIXELS_DEF,
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int SETTLE_SAMPLES = SETTLE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_arm,
    input  logic              i_adc_valid,
    input  logic [DATA_W-1:0] i_adc_data,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_wdata,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic              o_overrun,
    output logic [DATA_W-1:0] o_min_val,
    output logic [DATA_W-1:0] o_max_val
);

    localparam logic [ADDR_W-1:0]   PIX_LAST    = ADDR_W'(N_PIXELS - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST =
        SETTLE_W'((SETTLE_SAMPLES > 0) ? (SETTLE_SAMPLES - 1) : 0);

    state_t              state_reg;
    state_t              state_next;
    logic [SETTLE_W-1:0] settle_cnt_reg;
    logic [ADDR_W-1:0]   pix_cnt_reg;

    logic arm_idle;
    logic accept;
    logic last_pix;
    logic settle_last;

    // An arm only starts a frame from IDLE; samples count only while capturing.
    assign arm_idle    = i_arm && (state_reg == ST_IDLE);
    assign accept      = i_adc_valid && (state_reg == ST_CAPTURE);
    assign last_pix    = (pix_cnt_reg == PIX_LAST);
    assign settle_last = (settle_cnt_reg == SETTLE_LAST);
    assign o_busy      = state_busy(state_reg);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state: arm -> settle (or straight to capture) -> capture N pixels -> one DONE cycle.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (i_arm) begin
                    state_next = (SETTLE_SAMPLES > 0) ? ST_SETTLE : ST_CAPTURE;
                end
            end
            ST_SETTLE: begin
                if (i_adc_valid && settle_last) begin
                    state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (accept && last_pix) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Discard and pixel counters; both restart on a fresh arm, the pixel count parks at the last index.
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt_reg <= '0;
            pix_cnt_reg    <= '0;
        end else if (arm_idle) begin
            settle_cnt_reg <= '0;
            pix_cnt_reg    <= '0;
        end else begin
            if ((state_reg == ST_SETTLE) && i_adc_valid) begin
                settle_cnt_reg <= settle_cnt_reg + 1'b1;
            end
            if (accept && !last_pix) begin
                pix_cnt_reg <= pix_cnt_reg + 1'b1;
            end
        end
    end

    // BRAM write port: one registered write per accepted sample, address/data hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_ram_we    <= 1'b0;
            o_ram_addr  <= '0;
            o_ram_wdata <= '0;
        end else begin
            o_ram_we <= accept;
            if (accept) begin
                o_ram_addr  <= pix_cnt_reg;
                o_ram_wdata <= i_adc_data;
            end
        end
    end

    // Frame-done pulse trails DONE by a cycle; overrun is sticky until the next accepted arm.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_frame_done <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_frame_done <= (state_reg == ST_DONE);
            if (arm_idle) begin
                o_overrun <= 1'b0;
            end else if (i_arm && o_busy) begin
                o_overrun <= 1'b1;
            end
        end
    end

    frame_minmax #(
        .DATA_W(DATA_W)
    ) u_minmax (
        .clk      (clk),
        .rst      (rst),
        .sample_en(accept),
        .first    (pix_cnt_reg == '0),
        .sample   (i_adc_data),
        .latch    (state_reg == ST_DONE),
        .min_val  (o_min_val),
        .max_val  (o_max_val)
    );

endmodule

// File: tb/tb_adc_frame_writer.sv
// Bench: two writers (settle 2 and settle 0) on shared stimulus, checked each cycle against a frame-level model.
module tb_adc_frame_writer;

    localparam int N  = 576;
    localparam int AW = 10;
    localparam int DW = 12;
    localparam int NI = 2;

    logic          clk;
    logic          rst;
    logic          arm;
    logic          valid;
    logic [DW-1:0] data;

    logic          we    [NI];
    logic [AW-1:0] addr  [NI];
    logic [DW-1:0] wdata [NI];
    logic          busy  [NI];
    logic          done  [NI];
    logic          ovr   [NI];
    logic [DW-1:0] vmin  [NI];
    logic [DW-1:0] vmax  [NI];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // model state: frame progress in plain counters
    bit            m_active [NI];
    bit            m_last   [NI];
    int            m_disc   [NI];
    int            m_idx    [NI];
    logic [DW-1:0] w_min    [NI];
    logic [DW-1:0] w_max    [NI];
    logic          e_we     [NI];
    logic [AW-1:0] e_addr   [NI];
    logic [DW-1:0] e_wd     [NI];
    logic          e_done   [NI];
    logic          e_ovr    [NI];
    logic [DW-1:0] e_min    [NI];
    logic [DW-1:0] e_max    [NI];

    // independent per-frame bookkeeping from the observed write stream
    int            wr_cnt      [NI];
    int            last_wr_cyc [NI];
    logic [DW-1:0] first_wd    [NI];

    adc_frame_writer #(.N_PIXELS(N), .ADDR_W(AW), .DATA_W(DW), .SETTLE_SAMPLES(2)) dut_s2 (
        .clk(clk), .rst(rst), .i_arm(arm), .i_adc_valid(valid), .i_adc_data(data),
        .o_ram_we(we[0]), .o_ram_addr(addr[0]), .o_ram_wdata(wdata[0]), .o_busy(busy[0]),
        .o_frame_done(done[0]), .o_overrun(ovr[0]), .o_min_val(vmin[0]), .o_max_val(vmax[0])
    );

    adc_frame_writer #(.N_PIXELS(N), .ADDR_W(AW), .DATA_W(DW), .SETTLE_SAMPLES(0)) dut_s0 (
        .clk(clk), .rst(rst), .i_arm(arm), .i_adc_valid(valid), .i_adc_data(data),
        .o_ram_we(we[1]), .o_ram_addr(addr[1]), .o_ram_wdata(wdata[1]), .o_busy(busy[1]),
        .o_frame_done(done[1]), .o_overrun(ovr[1]), .o_min_val(vmin[1]), .o_max_val(vmax[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int settle_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Frame-level reference: each edge consumes the sampled inputs and yields the expected outputs.
    initial begin
        for (int i = 0; i < NI; i++) begin
            wr_cnt[i] = 0;
            last_wr_cyc[i] = -100;
            first_wd[i] = '0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            for (int i = 0; i < NI; i++) begin
                if (rst) begin
                    m_active[i] = 0; m_last[i] = 0; m_disc[i] = 0; m_idx[i] = 0;
                    w_min[i] = '0; w_max[i] = '0;
                    e_we[i] = 0; e_addr[i] = '0; e_wd[i] = '0; e_done[i] = 0;
                    e_ovr[i] = 0; e_min[i] = '0; e_max[i] = '0;
                end else begin
                    e_we[i]   = 0;
                    e_done[i] = 0;
                    if (m_last[i]) begin
                        // frame finished: publish extrema, announce, go idle
                        if (arm) e_ovr[i] = 1;
                        e_done[i]   = 1;
                        e_min[i]    = w_min[i];
                        e_max[i]    = w_max[i];
                        m_last[i]   = 0;
                        m_active[i] = 0;
                    end else if (!m_active[i]) begin
                        if (arm) begin
                            m_active[i] = 1;
                            m_disc[i]   = settle_of(i);
                            m_idx[i]    = 0;
                            e_ovr[i]    = 0;
                        end
                    end else begin
                        if (arm) e_ovr[i] = 1;
                        if (valid) begin
                            if (m_disc[i] > 0) begin
                                m_disc[i]--;
                            end else begin
                                e_we[i]   = 1;
                                e_addr[i] = AW'(m_idx[i]);
                                e_wd[i]   = data;
                                if (m_idx[i] == 0) begin
                                    w_min[i] = data;
                                    w_max[i] = data;
                                end else begin
                                    if (data < w_min[i]) w_min[i] = data;
                                    if (data > w_max[i]) w_max[i] = data;
                                end
                                if (m_idx[i] == N - 1) m_last[i] = 1;
                                else m_idx[i]++;
                            end
                        end
                    end
                end
            end
        end
    end

    // Compare every output of both writers against the model each cycle, plus write-stream bookkeeping.
    initial begin
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                for (int i = 0; i < NI; i++) begin
                    chk($sformatf("outputs_s%0d {we,addr,wdata,busy,done,ovr,min,max}", settle_of(i)),
                        64'({we[i], addr[i], wdata[i], busy[i], done[i], ovr[i], vmin[i], vmax[i]}),
                        64'({e_we[i], e_addr[i], e_wd[i], m_active[i], e_done[i], e_ovr[i], e_min[i], e_max[i]}));
                    if (we[i] === 1'b1) begin
                        wr_cnt[i]++;
                        if (addr[i] == 0) first_wd[i] = wdata[i];
                        if (addr[i] == AW'(N - 1)) last_wr_cyc[i] = cyc;
                    end
                    if (done[i] === 1'b1) begin
                        chk($sformatf("done_after_last_write_s%0d", settle_of(i)), 64'(cyc - last_wr_cyc[i]), 64'd1);
                        chk($sformatf("writes_per_frame_s%0d", settle_of(i)), 64'(wr_cnt[i]), 64'(N));
                        $display("frame settle=%0d done at cycle %0d: min=%0h max=%0h writes=%0d",
                                 settle_of(i), cyc, vmin[i], vmax[i], wr_cnt[i]);
                        wr_cnt[i] = 0;
                    end
                    if (rst) wr_cnt[i] = 0;
                end
            end
        end
    end

    task automatic step(input logic a, input logic v, input logic [DW-1:0] d);
        arm = a; valid = v; data = d;
        @(posedge clk);
        #1;
    endtask

    // Arm, then feed samples until both writers are idle.
    // mode 0: data = index of valid sample, 1: random, 2: constant cval.
    // period 0: random valid density, else one valid every 'period' cycles. arm_at re-arms mid-frame.
    task automatic run_frame(input int mode, input int period, input logic [DW-1:0] cval, input int arm_at);
        int  k = 0;
        bit  v;
        bit  finished = 0;
        logic [DW-1:0] d;
        step(1'b1, 1'b0, '0);
        for (int n = 0; n < 5000; n++) begin
            if (!m_active[0] && !m_active[1]) begin
                finished = 1;
                break;
            end
            v = (period == 0) ? ($urandom_range(0, 1) == 1) : ((n % period) == period - 1);
            d = (mode == 0) ? DW'(k) : (mode == 1) ? DW'($urandom) : cval;
            if (v) k++;
            step(n == arm_at, v, d);
        end
        chk("frame_completes_within_budget", 64'(finished), 64'd1);
        step(1'b0, 1'b0, '0);
    endtask

    initial begin
        bit hit;
        rst = 1'b1; arm = 1'b0; valid = 1'b0; data = '0;
        repeat (3) step(1'b0, 1'b1, 12'h5A5);
        rst = 1'b0;
        step(1'b0, 1'b0, '0);
        for (int i = 0; i < NI; i++)
            chk($sformatf("reset_outputs_s%0d", settle_of(i)),
                64'({we[i], addr[i], wdata[i], busy[i], done[i], ovr[i], vmin[i], vmax[i]}), 64'd0);

        // ramp frame: value = sample index, valid every cycle
        run_frame(0, 1, '0, -1);
        chk("ramp_min_s2", 64'(vmin[0]), 64'd2);
        chk("ramp_max_s2", 64'(vmax[0]), 64'd577);
        chk("ramp_first_data_s2", 64'(first_wd[0]), 64'd2);
        chk("ramp_min_s0", 64'(vmin[1]), 64'd0);
        chk("ramp_max_s0", 64'(vmax[1]), 64'd575);

        // sparse valid: one sample every third cycle
        run_frame(1, 3, '0, -1);

        // arm during capture raises overrun without disturbing the frame
        run_frame(1, 0, '0, 60);
        chk("overrun_sticky_s2", 64'(ovr[0]), 64'd1);
        chk("overrun_sticky_s0", 64'(ovr[1]), 64'd1);
        step(1'b1, 1'b0, '0);
        chk("overrun_cleared_by_arm_s2", 64'(ovr[0]), 64'd0);
        chk("overrun_cleared_by_arm_s0", 64'(ovr[1]), 64'd0);
        run_frame(1, 0, '0, -1);

        // reset right after the write to address 100 aborts the frame
        step(1'b1, 1'b0, '0);
        hit = 0;
        for (int n = 0; n < 400; n++) begin
            step(1'b0, 1'b1, DW'($urandom));
            if (we[0] === 1'b1 && addr[0] == 100) begin
                hit = 1;
                break;
            end
        end
        chk("reached_addr_100", 64'(hit), 64'd1);
        rst = 1'b1;
        step(1'b0, 1'b1, 12'h777);
        rst = 1'b0;
        chk("abort_outputs_s2", 64'({we[0], addr[0], wdata[0], busy[0], done[0], ovr[0], vmin[0], vmax[0]}), 64'd0);
        repeat (5) step(1'b0, 1'b1, 12'h111);

        // arm with a same-cycle sample: that sample is dropped
        step(1'b1, 1'b1, 12'hABC);
        step(1'b0, 1'b1, 12'h123);
        run_frame(1, 0, '0, -1);
        chk("same_cycle_sample_dropped_s0", 64'(first_wd[1]), 64'h123);

        // constant frames pin the extrema
        run_frame(2, 1, 12'hFFF, -1);
        chk("const_fff_min_s2", 64'(vmin[0]), 64'hFFF);
        chk("const_fff_max_s0", 64'(vmax[1]), 64'hFFF);
        run_frame(2, 2, 12'h000, -1);
        chk("const_000_min_s0", 64'(vmin[1]), 64'h000);
        chk("const_000_max_s2", 64'(vmax[0]), 64'h000);

        // random frames with occasional stray arms
        for (int f = 0; f < 3; f++)
            run_frame(1, 0, '0, int'($urandom_range(0, 900)));

        repeat (4) step(1'b0, 1'b0, '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
